// File: rtl/crc8_pkg.sv
// +----------------------------------------------------------------------------+
// | crc8_pkg: CRC-8/MAXIM constants, update rule and checker state type.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package crc8_pkg;

  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
  localparam logic [7:0] CRC8_INIT      = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RESULT = 2'd2
  } crc_chk_state_e;

  // Reflected (right-shift) single-bit update; shared with the generator.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC8_POLY_REFL : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc8_lfsr.sv
// +----------------------------------------------------------------------------+
// | crc8_lfsr: bit-serial CRC-8/MAXIM engine with init and step controls.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc8_lfsr
  import crc8_pkg::*;
#(
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       init_i,
  input  logic       step_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Init takes priority so a frame restart never absorbs a stray bit.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = INIT;
    end else if (step_i) begin
      crc_d = crc8_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/crc8_checker.sv
// +----------------------------------------------------------------------------+
// | crc8_checker: receive-side CRC-8/MAXIM frame checker with error counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc8_checker
  import crc8_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter int         ERR_CNT_W = 8,
  parameter logic [7:0] CRC_INIT  = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [7:0]           s_data_i,
  input  logic                 s_last_i,
  output logic                 res_valid_o,
  output logic                 res_ok_o,
  output logic [7:0]           res_crc_o,
  output logic [LEN_W-1:0]     res_len_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  localparam logic [LEN_W-1:0]     LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  crc_chk_state_e       state_q,   state_d;
  logic [7:0]           sr_q,      sr_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]     len_q,     len_d;
  logic [LEN_W-1:0]     res_len_q, res_len_d;
  logic [7:0]           res_crc_q, res_crc_d;
  logic                 ok_q,      ok_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       accept;
  logic       lfsr_init;
  logic       lfsr_step;
  logic [7:0] crc;

  crc8_lfsr #(
    .INIT (CRC_INIT)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .init_i (lfsr_init),
    .step_i (lfsr_step),
    .bit_i  (sr_q[0]),
    .crc_o  (crc)
  );

  assign s_ready_o = (state_q == IDLE);
  assign accept    = s_valid_i & s_ready_o;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    res_len_d = res_len_q;
    res_crc_d = res_crc_q;
    ok_d      = ok_q;
    err_cnt_d = err_cnt_q;
    lfsr_init = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!s_last_i) begin
            sr_d      = s_data_i;
            bit_cnt_d = 3'd0;
            state_d   = SHIFT;
            if (len_q != {LEN_W{1'b1}}) begin
              len_d = len_q + LEN_ONE;
            end
          end else begin
            // The CRC byte itself is compared, never shifted through the engine.
            ok_d      = (s_data_i == crc);
            res_crc_d = crc;
            res_len_d = len_q;
            state_d   = RESULT;
          end
        end
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        sr_d      = sr_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      RESULT: begin
        lfsr_init = 1'b1;
        len_d     = '0;
        state_d   = IDLE;
        if (!ok_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_clr_i) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      len_q     <= '0;
      res_len_q <= '0;
      res_crc_q <= 8'h00;
      ok_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      res_len_q <= res_len_d;
      res_crc_q <= res_crc_d;
      ok_q      <= ok_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign res_valid_o = (state_q == RESULT);
  assign res_ok_o    = ok_q;
  assign res_crc_o   = res_crc_q;
  assign res_len_o   = res_len_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_crc8_checker.sv
// +----------------------------------------------------------------------------+
// | tb_crc8_checker: directed self-checking bench for crc8_checker.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_crc8_checker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [7:0]  s_data_i;
  logic        s_last_i;
  logic        res_valid_o;
  logic        res_ok_o;
  logic [7:0]  res_crc_o;
  logic [15:0] res_len_o;
  logic [7:0]  err_cnt_o;
  logic        err_clr_i;

  // Narrow-counter instance sharing the same stream, for saturation.
  logic        s_ready_b;
  logic        res_valid_b;
  logic        res_ok_b;
  logic [7:0]  res_crc_b;
  logic [15:0] res_len_b;
  logic [1:0]  err_cnt_b;

  int n_checks = 0;
  int n_fails  = 0;
  int acc_cnt  = 0;

  always #5 clk_i = ~clk_i;

  crc8_checker #(.LEN_W(16), .ERR_CNT_W(8), .CRC_INIT(8'h00)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .res_valid_o (res_valid_o),
    .res_ok_o    (res_ok_o),
    .res_crc_o   (res_crc_o),
    .res_len_o   (res_len_o),
    .err_cnt_o   (err_cnt_o),
    .err_clr_i   (err_clr_i)
  );

  crc8_checker #(.LEN_W(16), .ERR_CNT_W(2), .CRC_INIT(8'h00)) dut_b (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_b),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .res_valid_o (res_valid_b),
    .res_ok_o    (res_ok_b),
    .res_crc_o   (res_crc_b),
    .res_len_o   (res_len_b),
    .err_cnt_o   (err_cnt_b),
    .err_clr_i   (err_clr_i)
  );

  always @(posedge clk_i) begin
    if (s_valid_i && s_ready_o) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; the byte is accepted on the rising edge in between.
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int t;
    if (gap > 0) begin
      s_valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
    end
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    t = 0;
    while (!s_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic send_last(input string tag, input logic [7:0] d, input logic exp_ok,
                           input logic [7:0] exp_crc, input logic [15:0] exp_len);
    send_byte(d, 1'b1, 0);
    check({tag, "_valid"}, 32'(res_valid_o), 32'd1);
    check({tag, "_ok"},    32'(res_ok_o),    32'(exp_ok));
    check({tag, "_crc"},   32'(res_crc_o),   32'(exp_crc));
    check({tag, "_len"},   32'(res_len_o),   32'(exp_len));
    @(negedge clk_i);
    check({tag, "_pulse_end"}, 32'(res_valid_o), 32'd0);
  endtask

  task automatic send_123456789(input int maxgap);
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) begin
      send_byte(msg[i], 1'b0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  initial begin
    int n;
    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    err_clr_i = 1'b0;
    #1;
    check("rst_ready",   32'(s_ready_o),   32'd1);
    check("rst_valid",   32'(res_valid_o), 32'd0);
    check("rst_ok",      32'(res_ok_o),    32'd0);
    check("rst_crc",     32'(res_crc_o),   32'd0);
    check("rst_len",     32'(res_len_o),   32'd0);
    check("rst_err",     32'(err_cnt_o),   32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: check string, correct CRC
    send_123456789(0);
    send_last("t1", 8'hA1, 1'b1, 8'hA1, 16'd9);
    check("t1_err", 32'(err_cnt_o), 32'd0);
    check("t1_hold_crc", 32'(res_crc_o), 32'hA1);

    // 2: wrong CRC, then clear
    send_123456789(0);
    send_last("t2", 8'hA0, 1'b0, 8'hA1, 16'd9);
    check("t2_err", 32'(err_cnt_o), 32'd1);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("t2_err_clr", 32'(err_cnt_o), 32'd0);

    // 3: single byte, ready gap of exactly 8 cycles
    send_byte(8'h01, 1'b0, 0);
    n = 0;
    while (!s_ready_o && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    check("t3_busy_cycles", 32'(n), 32'd8);
    send_last("t3", 8'h5E, 1'b1, 8'h5E, 16'd1);

    // 4: zero-data frames
    send_last("t4a", 8'h00, 1'b1, 8'h00, 16'd0);
    send_last("t4b", 8'hFF, 1'b0, 8'h00, 16'd0);
    check("t4_err", 32'(err_cnt_o), 32'd1);

    // 5: valid held through busy periods, random idle gaps
    acc_cnt = 0;
    send_123456789(3);
    send_last("t5a", 8'hA1, 1'b1, 8'hA1, 16'd9);
    check("t5_accepts", 32'(acc_cnt), 32'd10);
    send_123456789(2);
    send_last("t5b", 8'hA1, 1'b1, 8'hA1, 16'd9);

    // 6: reset mid-frame
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0, 0);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_ready", 32'(s_ready_o),   32'd1);
    check("t6_rst_valid", 32'(res_valid_o), 32'd0);
    check("t6_rst_err",   32'(err_cnt_o),   32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (res_valid_o) n++;
    end
    check("t6_no_result", 32'(n), 32'd0);
    send_byte(8'h01, 1'b0, 0);
    send_last("t6", 8'h5E, 1'b1, 8'h5E, 16'd1);

    // Saturation: five bad frames; wide counter counts, 2-bit one pins at 3
    for (int i = 0; i < 5; i++) send_last("sat", 8'hFF, 1'b0, 8'h00, 16'd0);
    check("sat_err_wide",   32'(err_cnt_o), 32'd5);
    check("sat_err_narrow", 32'(err_cnt_b), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
